alu_unit: RTL
=============

// Module: alu_unit
// PURPOSE
//  SAP-II arithmetic/logic stage directly downstream of the accumulator. It consumes the
//  accumulator's always-driven 8-bit output and a TMP operand register loaded from WBUS.
//  It computes the selected operation and drives the result onto WBUS when enabled.
//  It holds the sign/zero flags used by JM/JZ/JNZ, and runs an 8-cycle shift-add multiply
//  with a start/busy/done handshake.
// PARAMETERS
//  WIDTH      8   data path width; WBUS, acc, TMP and the product register
//  MUL_STEPS  8   multiply iterations; must equal WIDTH
// PORTS
//  CLK    input   1      clock; all state updates on posedge
//  nCLR   input   1      asynchronous active-low reset
//  WBUS   inout   WIDTH  system bus; TMP loads from it, result drives it
//  acc    input   WIDTH  accumulator contents (accumulator alu output)
//  op     input   4      operation select (see BEHAVIOUR)
//  nLt    input   1      0 -> load TMP from WBUS at posedge
//  Eu     input   1      1 -> drive result onto WBUS
//  nLf    input   1      0 -> load sign/zero flags from result at posedge
//  start  input   1      1 with op=MUL -> launch multiply at posedge
//  busy   output  1      multiply in progress
//  done   output  1      one-cycle pulse on multiply completion
//  sign   output  1      sign flag
//  zero   output  1      zero flag
// BEHAVIOUR
//  - Reset, asynchronous on nCLR=0: TMP=0, prod=0, sign=0, zero=0, busy=0, done=0.
//    The FSM goes to IDLE and WBUS is High-Z. Reset mid-multiply aborts it; no done pulse.
//  - Op encoding (all results WIDTH bits, carry discarded, mod 2^WIDTH):
//    - 0 ADD acc+TMP; 1 SUB acc-TMP (two's complement); 2 ANA acc&TMP; 3 ORA acc|TMP
//    - 4 XRA acc^TMP; 5 CMA ~acc
//    - 6 RAL {acc[6:0],acc[7]}; 7 RAR {acc[0],acc[7:1]}
//    - 8 INR TMP+1; 9 DCR TMP-1; 10 MUL = prod register; 11-15 pass acc
//  - Ops 0-9 and 11-15 are combinational from acc/TMP/op; zero latency to WBUS.
//  - WBUS = result when Eu=1 and busy=0; otherwise High-Z. Eu during busy is High-Z.
//  - TMP: nLt=0 at posedge -> TMP<=WBUS; otherwise holds. nLt has priority over nothing else.
//  - Flags: nLf=0 at posedge and busy=0 -> sign<=result[7], zero<=(result==0).
//    nLf during busy is ignored and the flags hold.
//  - FSM states IDLE, RUN:
//    - IDLE -> RUN: posedge with start=1 and op=10.
//      - Captures mcand=acc and mplier=TMP; clears the 16-bit partial sum and sets count=0.
//    - In RUN, each posedge:
//      - if mplier[0], partial += mcand << count
//      - mplier >>= 1; count++
//    - RUN -> IDLE: on the posedge that completes step MUL_STEPS.
//      - prod <= low WIDTH bits of the full sum; done=1 for exactly the following cycle.
//  - Timing: start sampled at edge N -> busy=1 from N to N+8. busy falls at edge N+8,
//    done=1 from N+8 to N+9, prod is valid from N+8.
//  - start in RUN is ignored. start with op!=10 is ignored.
//  - Changes to acc or TMP during RUN do not affect the product.
//  - nLt during RUN still loads TMP (the operand was already captured).
//  - Back-to-back: start=1 during the done cycle launches a new multiply.
// TESTING
//  - Reset: nCLR=0 mid-cycle -> WBUS=zzzz_zzzz, sign=0, zero=0, busy=0, done=0 immediately.
//  - ADD: acc=0x0A, TMP loaded 0x20 via nLt, op=0, Eu=1 -> WBUS=0x2A.
//    Then nLf pulse -> sign=0, zero=0.
//  - SUB/flags: acc=0x05, TMP=0x05, op=1, nLf pulse -> zero=1, sign=0.
//    Then TMP=0x07 -> result 0xFE, nLf pulse -> sign=1, zero=0.
//  - Logic/rotate: acc=0x81, TMP=0x0F:
//    - ANA 0x01, ORA 0x8F, XRA 0x8E, CMA 0x7E
//    - RAL 0x03, RAR 0xC0, INR 0x10, DCR 0x0E
//  - MUL: acc=12, TMP=13, op=10, start pulse at edge N:
//    - busy=1 for 8 cycles; done=1 only from N+8 to N+9
//    - Eu=1 after done -> WBUS=0x9C
//    - Eu=1 while busy -> High-Z
//  - MUL wrap, abort and ignore:
//    - 16*16 -> WBUS=0x00; nLf pulse -> zero=1
//    - Restart, assert nCLR=0 at cycle 4 -> busy=0 at once, prod=0, no done pulse
//    - start during RUN -> no effect on the cycle count or the result

Source files
------------

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// SAP-II arithmetic/logic stage that sits directly after the accumulator.
// It combines the accumulator output with a TMP operand register loaded from
// WBUS, and drives the selected result back onto WBUS when enabled. It also
// holds the sign/zero flags used by conditional jumps, and contains a
// multi-cycle shift-add multiplier controlled by a start/busy/done handshake.
//
// Ports
//   CLK    in     clock, all state changes on posedge
//   nCLR   in     asynchronous active-low clear
//   WBUS   inout  system bus: TMP loads from it, the result drives it
//   acc    in     accumulator contents
//   op     in     operation select
//   nLt    in     0 -> load TMP from WBUS
//   Eu     in     1 -> drive the result onto WBUS (only while not busy)
//   nLf    in     0 -> load sign/zero from the result (only while not busy)
//   start  in     1 with op=MUL -> launch a multiply
//   busy   out    multiply in progress
//   done   out    one-cycle pulse when a multiply completes
//   sign   out    sign flag
//   zero   out    zero flag
// -----------------------------------------------------------------------------
module alu_unit #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MUL_STEPS = 8  // must equal WIDTH
) (
   input  logic             CLK,
   input  logic             nCLR,
   inout  wire  [WIDTH-1:0] WBUS,
   input  logic [WIDTH-1:0] acc,
   input  logic [3:0]       op,
   input  logic             nLt,
   input  logic             Eu,
   input  logic             nLf,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             sign,
   output logic             zero
);

   localparam int unsigned CW = $clog2(MUL_STEPS + 1);

   localparam logic [3:0] OpAdd = 4'd0;
   localparam logic [3:0] OpSub = 4'd1;
   localparam logic [3:0] OpAna = 4'd2;
   localparam logic [3:0] OpOra = 4'd3;
   localparam logic [3:0] OpXra = 4'd4;
   localparam logic [3:0] OpCma = 4'd5;
   localparam logic [3:0] OpRal = 4'd6;
   localparam logic [3:0] OpRar = 4'd7;
   localparam logic [3:0] OpInr = 4'd8;
   localparam logic [3:0] OpDcr = 4'd9;
   localparam logic [3:0] OpMul = 4'd10;

   typedef enum logic {StIdle, StRun} state_t;

   state_t             state;
   logic [WIDTH-1:0]   tmp;
   logic [WIDTH-1:0]   prod;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] partial;
   logic [CW-1:0]      count;

   logic [WIDTH-1:0]   result;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] partial_next;
   logic               last_step;

   // Result selection; carries are dropped, everything is mod 2^WIDTH.
   always_comb begin
      result = acc;
      case (op)
         OpAdd:   result = acc + tmp;
         OpSub:   result = acc - tmp;
         OpAna:   result = acc & tmp;
         OpOra:   result = acc | tmp;
         OpXra:   result = acc ^ tmp;
         OpCma:   result = ~acc;
         OpRal:   result = {acc[WIDTH-2:0], acc[WIDTH-1]};
         OpRar:   result = {acc[0], acc[WIDTH-1:1]};
         OpInr:   result = tmp + WIDTH'(1);
         OpDcr:   result = tmp - WIDTH'(1);
         OpMul:   result = prod;
         default: result = acc;
      endcase
   end

   // One shift-add step: add the multiplicand, shifted to the current bit
   // position, whenever the current low multiplier bit is set.
   always_comb begin
      addend       = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << count) : '0;
      partial_next = partial + addend;
      last_step    = (count == CW'(MUL_STEPS - 1));
   end

   // The bus is released during a multiply and while clear is held.
   assign WBUS = (nCLR && Eu && !busy) ? result : {WIDTH{1'bz}};

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state   <= StIdle;
         tmp     <= '0;
         prod    <= '0;
         mcand   <= '0;
         mplier  <= '0;
         partial <= '0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sign    <= 1'b0;
         zero    <= 1'b0;
      end else begin
         // TMP may load even mid-multiply; the operand was captured at launch.
         if (!nLt) begin
            tmp <= WBUS;
         end
         if (!nLf && !busy) begin
            sign <= result[WIDTH-1];
            zero <= (result == '0);
         end
         done <= 1'b0;
         case (state)
            StIdle: begin
               if (start && (op == OpMul)) begin
                  mcand   <= acc;
                  mplier  <= tmp;
                  partial <= '0;
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= StRun;
               end
            end
            StRun: begin
               partial <= partial_next;
               mplier  <= mplier >> 1;
               count   <= count + CW'(1);
               if (last_step) begin
                  prod  <= partial_next[WIDTH-1:0];
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
